// File: rtl/pe_relay_fifo.sv
// pe_relay_fifo: four independent per-direction FIFOs with shared drain enable and idle flag.
module pe_relay_fifo_ch #(
  parameter int W = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ap_start,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         empty
);
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] cnt;
  logic push, pop;
  // ready also gates on reset so nothing is accepted while the block is held in reset
  assign in_ready = reset && (cnt < DEPTH);
  assign empty = cnt == '0;
  assign out_valid = ap_start && !empty;
  assign out_data = out_valid ? mem[rp] : '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= push && !pop ? cnt + 1'b1 : pop && !push ? cnt - 1'b1 : cnt;
    end
  end
endmodule

module pe_relay_fifo #(
  parameter int EAST_WIDTH = 130,
  parameter int WEST_WIDTH = 130,
  parameter int NORTH_WIDTH = 200,
  parameter int SOUTH_WIDTH = 167,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ap_start,
  output logic                   ap_idle,
  input  logic [EAST_WIDTH-1:0]  in_from_east,
  input  logic                   in_from_east_valid,
  output logic                   in_from_east_ready,
  output logic [EAST_WIDTH-1:0]  out_to_east,
  output logic                   out_to_east_valid,
  input  logic                   out_to_east_ready,
  input  logic [WEST_WIDTH-1:0]  in_from_west,
  input  logic                   in_from_west_valid,
  output logic                   in_from_west_ready,
  output logic [WEST_WIDTH-1:0]  out_to_west,
  output logic                   out_to_west_valid,
  input  logic                   out_to_west_ready,
  input  logic [NORTH_WIDTH-1:0] in_from_north,
  input  logic                   in_from_north_valid,
  output logic                   in_from_north_ready,
  output logic [NORTH_WIDTH-1:0] out_to_north,
  output logic                   out_to_north_valid,
  input  logic                   out_to_north_ready,
  input  logic [SOUTH_WIDTH-1:0] in_from_south,
  input  logic                   in_from_south_valid,
  output logic                   in_from_south_ready,
  output logic [SOUTH_WIDTH-1:0] out_to_south,
  output logic                   out_to_south_valid,
  input  logic                   out_to_south_ready
);
  logic [3:0] empty;
  assign ap_idle = &empty;
  pe_relay_fifo_ch #(.W(EAST_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_east (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data(in_from_east), .in_valid(in_from_east_valid), .in_ready(in_from_east_ready),
    .out_data(out_to_east), .out_valid(out_to_east_valid), .out_ready(out_to_east_ready),
    .empty(empty[0]));
  pe_relay_fifo_ch #(.W(WEST_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_west (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data(in_from_west), .in_valid(in_from_west_valid), .in_ready(in_from_west_ready),
    .out_data(out_to_west), .out_valid(out_to_west_valid), .out_ready(out_to_west_ready),
    .empty(empty[1]));
  pe_relay_fifo_ch #(.W(NORTH_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_north (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data(in_from_north), .in_valid(in_from_north_valid), .in_ready(in_from_north_ready),
    .out_data(out_to_north), .out_valid(out_to_north_valid), .out_ready(out_to_north_ready),
    .empty(empty[2]));
  pe_relay_fifo_ch #(.W(SOUTH_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_south (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data(in_from_south), .in_valid(in_from_south_valid), .in_ready(in_from_south_ready),
    .out_data(out_to_south), .out_valid(out_to_south_valid), .out_ready(out_to_south_ready),
    .empty(empty[3]));
endmodule

// File: tb/tb_pe_relay_fifo.sv
// tb_pe_relay_fifo: directed vectors with hand-computed expectations for pe_relay_fifo.
module tb_pe_relay_fifo;
  logic clk = 1'b0;
  logic reset, ap_start, ap_idle;
  logic [129:0] e_in, e_out, w_in, w_out;
  logic [199:0] n_in, n_out;
  logic [166:0] s_in, s_out;
  logic e_iv, e_ir, e_ov, e_or, w_iv, w_ir, w_ov, w_or;
  logic n_iv, n_ir, n_ov, n_or, s_iv, s_ir, s_ov, s_or;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  pe_relay_fifo dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle),
    .in_from_east(e_in), .in_from_east_valid(e_iv), .in_from_east_ready(e_ir),
    .out_to_east(e_out), .out_to_east_valid(e_ov), .out_to_east_ready(e_or),
    .in_from_west(w_in), .in_from_west_valid(w_iv), .in_from_west_ready(w_ir),
    .out_to_west(w_out), .out_to_west_valid(w_ov), .out_to_west_ready(w_or),
    .in_from_north(n_in), .in_from_north_valid(n_iv), .in_from_north_ready(n_ir),
    .out_to_north(n_out), .out_to_north_valid(n_ov), .out_to_north_ready(n_or),
    .in_from_south(s_in), .in_from_south_valid(s_iv), .in_from_south_ready(s_ir),
    .out_to_south(s_out), .out_to_south_valid(s_ov), .out_to_south_ready(s_or));
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ni, no;
    reset = 1'b0; ap_start = 1'b0;
    {e_in, w_in, n_in, s_in} = '0;
    {e_iv, w_iv, n_iv, s_iv, e_or, w_or, n_or, s_or} = '0;
    tick;
    check("rst_idle", 256'(ap_idle), 256'(1));
    check("rst_e_ready", 256'(e_ir), 256'(0));
    reset = 1'b1;
    #1;
    check("rel_e_ready", 256'(e_ir), 256'(1));
    check("rel_e_valid", 256'(e_ov), 256'(0));
    check("rel_e_out", 256'(e_out), 256'(0));
    // basic pass through east
    ap_start = 1'b1; e_or = 1'b1; e_in = 130'h1; e_iv = 1'b1;
    tick;
    e_iv = 1'b0;
    #1;
    check("pass_valid", 256'(e_ov), 256'(1));
    check("pass_data", 256'(e_out), 256'(1));
    check("pass_idle", 256'(ap_idle), 256'(0));
    tick;
    check("pass_valid_after", 256'(e_ov), 256'(0));
    check("pass_idle_after", 256'(ap_idle), 256'(1));
    // fill north, reject fifth word, drain in order
    for (int i = 0; i < 4; i++) begin
      n_in = 200'(10 + i); n_iv = 1'b1;
      tick;
    end
    check("fill_ready", 256'(n_ir), 256'(0));
    n_in = 200'hE;
    tick;
    n_iv = 1'b0; n_or = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fill_data", 256'(n_out), 256'(10 + i));
      tick;
    end
    check("fill_no_e", 256'(n_ov), 256'(0));
    n_or = 1'b0;
    // full south with simultaneous pop attempt
    for (int i = 1; i <= 4; i++) begin
      s_in = 167'(i); s_iv = 1'b1;
      tick;
    end
    s_in = 167'h5; s_or = 1'b1;
    #1;
    check("full_ready", 256'(s_ir), 256'(0));
    check("full_head", 256'(s_out), 256'(1));
    tick;
    s_iv = 1'b0;
    #1;
    check("full_ready_next", 256'(s_ir), 256'(1));
    for (int i = 2; i <= 4; i++) begin
      check("full_drain", 256'(s_out), 256'(i));
      tick;
    end
    check("full_count3", 256'(s_ov), 256'(0));
    s_or = 1'b0;
    // stream 0..9 through west with random downstream ready
    ni = 0; no = 0;
    for (int c = 0; c < 200 && no < 10; c++) begin
      w_iv = ni < 10; w_in = 130'(ni); w_or = 1'($urandom_range(0, 1));
      #1;
      if (w_ov && w_or) begin
        check("wrap_data", 256'(w_out), 256'(no));
        no++;
      end
      if (w_iv && w_ir) ni++;
      tick;
    end
    w_iv = 1'b0; w_or = 1'b0;
    check("wrap_count", 256'(no), 256'(10));
    // ap_start gating on east
    ap_start = 1'b0; e_or = 1'b1;
    e_in = 130'h11; e_iv = 1'b1;
    tick;
    e_in = 130'h22;
    tick;
    e_iv = 1'b0;
    #1;
    check("gate_valid", 256'(e_ov), 256'(0));
    check("gate_out", 256'(e_out), 256'(0));
    check("gate_idle", 256'(ap_idle), 256'(0));
    ap_start = 1'b1;
    #1;
    check("gate_d0", 256'(e_out), 256'(17));
    tick;
    check("gate_d1", 256'(e_out), 256'(34));
    ap_start = 1'b0;
    #1;
    check("gate_drop", 256'(e_ov), 256'(0));
    ap_start = 1'b1;
    #1;
    check("gate_hold", 256'(e_out), 256'(34));
    tick;
    check("gate_empty", 256'(e_ov), 256'(0));
    e_or = 1'b0;
    // mid-operation reset with three words in every channel
    ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {e_iv, w_iv, n_iv, s_iv} = 4'hF;
      e_in = 130'(i + 'h40); w_in = 130'(i + 'h50); n_in = 200'(i + 'h60); s_in = 167'(i + 'h70);
      tick;
    end
    reset = 1'b0; ap_start = 1'b1;
    tick;
    check("mrst_ready", 256'({e_ir, w_ir, n_ir, s_ir}), 256'(0));
    check("mrst_valid", 256'({e_ov, w_ov, n_ov, s_ov}), 256'(0));
    check("mrst_idle", 256'(ap_idle), 256'(1));
    {e_iv, w_iv, s_iv} = 3'b0;
    reset = 1'b1; n_in = 200'h77;
    #1;
    check("mrst_ready_rel", 256'({e_ir, w_ir, n_ir, s_ir}), 256'hF);
    check("mrst_out", 256'(e_out), 256'(0));
    tick;
    n_iv = 1'b0;
    #1;
    check("mrst_new", 256'(n_out), 256'h77);
    n_or = 1'b1;
    tick;
    check("mrst_no_old", 256'({e_ov, w_ov, n_ov, s_ov}), 256'(0));
    check("mrst_idle_end", 256'(ap_idle), 256'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
